// File: rtl/mc_core_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, functs, controller states and ALU operations.
// Also provides the legality check that decode uses to choose between EXEC and HALT.
package mc_core_pkg;

  localparam int         NREGS  = 32;
  localparam logic [4:0] RA_REG = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  function automatic logic legal_instr(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: ok = (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR});
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32 x DW register file, two combinational read ports, one write port; r0 is hard-wired to zero.
// Writes land on the rising edge; the whole array clears asynchronously while rst is low.
module mc_regfile
  import mc_core_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [4:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [4:0]    raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [4:0]    raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/mc_core_hs.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB controller, 3-5 cycles per instruction at zero wait.
// Memory handshake: request held stable in FETCH/MEM until mem_ready; illegal instructions park in HALT.
module mc_core_hs
  import mc_core_pkg::*;
#(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          halted,
  output logic [31:0]   retired
);

  localparam logic [DW-1:0] PC_INC = DW'(4);

  state_e        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0]   ir_q, ir_d, retired_q, retired_d;

  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;

  logic [5:0]    opcode, funct;
  logic [DW-1:0] sext_imm, br_off, jtarget, alu_b, alu_res;
  alu_op_e       alu_op;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{(DW-16){ir_q[15]}}, ir_q[15:0]};
  assign br_off   = {sext_imm[DW-3:0], 2'b00};
  // pc_q already holds pc+4 by EXEC, so its top bits select the jump region.
  assign jtarget  = {pc_q[DW-1:28], ir_q[25:0], 2'b00};

  mc_regfile #(.DW(DW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (ir_q[25:21]),
    .rdata_a (rf_rdata_a),
    .raddr_b (ir_q[20:16]),
    .rdata_b (rf_rdata_b)
  );

  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end
    alu_b = (opcode == OP_RTYPE) ? b_q : sext_imm;
    case (alu_op)
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
      default: alu_res = a_q + alu_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = legal_instr(opcode, funct) ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ, OP_J: state_d = S_FETCH;
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_FETCH : S_WB;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM:    if (mem_ready) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    mem_req   = rst && ((state_q == S_FETCH) || (state_q == S_MEM));
    mem_we    = (state_q == S_MEM) && (opcode == OP_SW);
    mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
    mem_wdata = b_q;
    halted    = (state_q == S_HALT);
    retired   = retired_q;

    pc_d = pc_q;  ir_d = ir_q;  a_d = a_q;  b_d = b_q;
    alu_d = alu_q;  mdr_d = mdr_q;  retired_d = retired_q;
    rf_we    = 1'b0;
    rf_waddr = ir_q[20:16];
    rf_wdata = alu_q;

    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d = mem_rdata[31:0];
        pc_d = pc_q + PC_INC;
      end
      S_DECODE: begin
        a_d = rf_rdata_a;
        b_d = rf_rdata_b;
      end
      S_EXEC: begin
        alu_d = (opcode == OP_JAL) ? pc_q : alu_res;
        if (opcode == OP_BEQ && a_q == b_q)              pc_d = pc_q + br_off;
        if (opcode == OP_J || opcode == OP_JAL)          pc_d = jtarget;
        if (opcode == OP_RTYPE && funct == FN_JR)        pc_d = a_q;
      end
      S_MEM: if (mem_ready) mdr_d = mem_rdata;
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OP_RTYPE) ? ir_q[15:11] :
                   (opcode == OP_JAL)   ? RA_REG      : ir_q[20:16];
        rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
      end
      default: ;
    endcase

    // An instruction retires on whichever edge returns the controller to FETCH.
    if (state_q != S_FETCH && state_d == S_FETCH) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_mc_core_hs.sv
// Directed bench for mc_core_hs at DW=32 and DW=64 with behavioural memories and a store scoreboard.
module tb_mc_core_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, rdy32, req32, we32, halt32;
  logic [31:0] addr32, wd32, rd32, ret32;
  logic        rst64, rdy64, req64, we64, halt64;
  logic [63:0] addr64, wd64, rd64;
  logic [31:0] ret64;

  mc_core_hs #(.DW(32), .RESET_PC(32'h0)) u_dut32 (
    .clk(clk), .rst(rst32), .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
    .mem_wdata(wd32), .mem_rdata(rd32), .mem_ready(rdy32), .halted(halt32), .retired(ret32));

  mc_core_hs #(.DW(64), .RESET_PC(64'h100)) u_dut64 (
    .clk(clk), .rst(rst64), .mem_req(req64), .mem_we(we64), .mem_addr(addr64),
    .mem_wdata(wd64), .mem_rdata(rd64), .mem_ready(rdy64), .halted(halt64), .retired(ret64));

  typedef struct packed { logic [63:0] addr; logic [63:0] data; } st_t;
  st_t exp32_q[$], exp64_q[$];
  st_t e32, e64;
  int  n_cmp = 0, n_fail = 0;

  logic [31:0] m32 [1024], img32 [1024], m64 [1024], img64 [1024];
  logic        load32 = 1'b0, load64 = 1'b0;
  logic [9:0]  idx64, idx64n;

  assign rd32   = m32[addr32[11:2]];
  assign idx64  = addr64[11:2];
  assign idx64n = idx64 + 10'd1;
  assign rd64   = {m64[idx64n], m64[idx64]};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memories: the only writers are these blocks; program images are copied in while held in reset.
  always @(posedge clk) begin
    if (load32) m32 <= img32;
    else if (rst32 && req32 && we32 && rdy32) begin
      m32[addr32[11:2]] <= wd32;
      n_cmp++;
      assert (exp32_q.size() > 0) else begin
        n_fail++;
        $error("FAIL st32_extra: observed store %h <= %h expected none", addr32, wd32);
      end
      if (exp32_q.size() > 0) begin
        e32 = exp32_q.pop_front();
        check("st32_addr", {32'd0, addr32}, e32.addr);
        check("st32_data", {32'd0, wd32}, e32.data);
      end
    end
  end

  always @(posedge clk) begin
    if (load64) m64 <= img64;
    else if (rst64 && req64 && we64 && rdy64) begin
      m64[idx64]  <= wd64[31:0];
      m64[idx64n] <= wd64[63:32];
      n_cmp++;
      assert (exp64_q.size() > 0) else begin
        n_fail++;
        $error("FAIL st64_extra: observed store %h <= %h expected none", addr64, wd64);
      end
      if (exp64_q.size() > 0) begin
        e64 = exp64_q.pop_front();
        check("st64_addr", addr64, e64.addr);
        check("st64_data", wd64, e64.data);
      end
    end
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] dv, nv, xw;
  int          bad;

  initial begin
    rst32 = 1'b0; rst64 = 1'b0; rdy32 = 1'b1; rdy64 = 1'b1;
    dv = 32'hDEADBEEF;
    nv = 32'd0 - dv;
    xw = enc_i(8'h2B, 0, 4, 16'h8C);

    // Program A: arithmetic + store, then a beq self-loop.
    for (int i = 0; i < 1024; i++) img32[i] = 32'hFC000000;
    img32[0] = enc_i(8'h08, 0, 1, 5);
    img32[1] = enc_i(8'h08, 0, 2, -3);
    img32[2] = enc_r(1, 2, 3, 8'h20);
    img32[3] = enc_i(8'h2B, 0, 3, 64);
    img32[4] = enc_i(8'h04, 0, 0, -1);
    load32 = 1'b1; tick(1); load32 = 1'b0;
    tick(1);
    check("rst_mem_req", req32, 0);
    check("rst_halted", halt32, 0);
    check("rst_retired", ret32, 0);
    exp32_q.push_back('{64'd64, 64'd2});
    rst32 = 1'b1;
    tick(15); check("A_retired_15", ret32, 3);
    tick(1);  check("A_retired_16", ret32, 4);
    check("A_mem64", m32[16], 2);
    check("A_store_seen", exp32_q.size(), 0);
    check("A_loop_fetch", {req32, addr32}, {1'b1, 32'd16});
    tick(2);  check("A_beq_mid", ret32, 4);
    tick(1);  check("A_beq_ret5", ret32, 5);
    check("A_beq_pc", {req32, addr32}, {1'b1, 32'd16});
    tick(3);  check("A_beq_ret6", ret32, 6);

    // Reset arriving while a fetch waits on memory.
    rdy32 = 1'b0;
    tick(2);
    check("D_fetch_hold", {req32, addr32}, {1'b1, 32'd16});
    #2 rst32 = 1'b0;
    #1 check("D_async_drop", req32, 0);
    check("D_retired_clr", ret32, 0);

    // Program B: stalled lw, store-then-fetch, jal/jr, slt/sub/or/and, branches.
    for (int i = 0; i < 1024; i++) img32[i] = 32'hFC000000;
    img32[0]  = enc_i(8'h23, 0, 4, 16'h80);
    img32[1]  = enc_i(8'h23, 0, 6, 16'h88);
    img32[2]  = enc_i(8'h2B, 0, 4, 16'h84);
    img32[3]  = enc_i(8'h2B, 0, 6, 16'h10);
    img32[5]  = enc_j(8'h03, 26'h18);
    img32[6]  = enc_i(8'h2B, 0, 31, 16'h90);
    img32[7]  = enc_r(4, 0, 7, 8'h2A);
    img32[8]  = enc_i(8'h2B, 0, 7, 16'h94);
    img32[9]  = enc_r(0, 4, 8, 8'h22);
    img32[10] = enc_r(4, 8, 9, 8'h25);
    img32[11] = enc_r(4, 8, 10, 8'h24);
    img32[12] = enc_i(8'h2B, 0, 8, 16'h98);
    img32[13] = enc_i(8'h2B, 0, 9, 16'h9C);
    img32[14] = enc_i(8'h2B, 0, 10, 16'hA0);
    img32[15] = enc_i(8'h04, 4, 0, 8);
    img32[16] = enc_i(8'h04, 0, 0, 2);
    img32[19] = enc_i(8'h04, 0, 0, -1);
    img32[24] = enc_r(31, 0, 0, 8'h08);
    img32[32] = dv;
    img32[34] = xw;
    load32 = 1'b1; tick(1); load32 = 1'b0;
    exp32_q.push_back('{64'h84, {32'd0, dv}});
    exp32_q.push_back('{64'h10, {32'd0, xw}});
    exp32_q.push_back('{64'h8C, {32'd0, dv}});
    exp32_q.push_back('{64'h90, 64'h18});
    exp32_q.push_back('{64'h94, 64'd1});
    exp32_q.push_back('{64'h98, {32'd0, nv}});
    exp32_q.push_back('{64'h9C, {32'd0, dv | nv}});
    exp32_q.push_back('{64'hA0, {32'd0, dv & nv}});
    rdy32 = 1'b1; rst32 = 1'b1;
    tick(2); rdy32 = 1'b0;
    tick(1); check("B_lw_hold", {req32, we32, addr32}, {2'b10, 32'h80});
    for (int k = 0; k < 3; k++) begin
      tick(1); check("B_lw_hold", {req32, we32, addr32}, {2'b10, 32'h80});
    end
    rdy32 = 1'b1;
    tick(1); check("B_lw_wb", ret32, 0);
    tick(1); check("B_lw_done", ret32, 1);
    check("B_next_fetch", {req32, addr32}, {1'b1, 32'h4});
    tick(150);
    check("B_stores_done", exp32_q.size(), 0);
    check("B_not_halted", halt32, 0);
    for (int k = 0; k < 4 && !req32; k++) tick(1);
    check("B_loop_pc", {req32, addr32}, {1'b1, 32'h4C});

    // Illegal opcode parks the core; reset restarts it at RESET_PC.
    rst32 = 1'b0;
    for (int i = 0; i < 1024; i++) img32[i] = 32'hFC000000;
    load32 = 1'b1; tick(1); load32 = 1'b0;
    rst32 = 1'b1;
    tick(1); check("C_decode", halt32, 0);
    tick(1); check("C_halted", {halt32, req32}, 2'b10);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (req32 !== 1'b0 || halt32 !== 1'b1) bad++;
    end
    check("C_halt_absorb", bad, 0);
    check("C_retired", ret32, 0);
    #2 rst32 = 1'b0;
    img32[0] = enc_r(0, 0, 0, 8'h3F);
    load32 = 1'b1; tick(1); load32 = 1'b0;
    rst32 = 1'b1;
    #1 check("C_restart_fetch", {halt32, req32, addr32}, {2'b01, 32'h0});
    tick(1); tick(1);
    check("C_bad_funct", halt32, 1);

    // DW=64 core, RESET_PC=0x100.
    for (int i = 0; i < 1024; i++) img64[i] = 32'hFC000000;
    img64[64] = enc_j(8'h03, 26'h50);
    img64[80] = enc_i(8'h08, 0, 1, -1);
    img64[81] = enc_r(1, 0, 2, 8'h2A);
    img64[82] = enc_i(8'h2B, 0, 1, 16'h200);
    img64[83] = enc_i(8'h2B, 0, 2, 16'h208);
    img64[84] = enc_i(8'h2B, 0, 31, 16'h210);
    img64[85] = enc_i(8'h04, 0, 0, -1);
    load64 = 1'b1; tick(1); load64 = 1'b0;
    check("E_rst_req", req64, 0);
    exp64_q.push_back('{64'h200, 64'hFFFF_FFFF_FFFF_FFFF});
    exp64_q.push_back('{64'h208, 64'd1});
    exp64_q.push_back('{64'h210, 64'h104});
    rst64 = 1'b1;
    #1 check("E_first_fetch", {63'd0, req64}, 64'd1);
    check("E_first_addr", addr64, 64'h100);
    tick(24);
    check("E_retired", ret64, 6);
    check("E_loop_addr", addr64, 64'h154);
    tick(20);
    check("E_stores_done", exp64_q.size(), 0);
    check("E_not_halted", halt64, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_core_hs.md
MC_CORE_HS -- requirements
Module: mc_core_hs

Interface
REQ-001 The module SHALL have parameter DW, default 32: datapath, register and memory-bus width; legal values 32 and 64.
REQ-002 The module SHALL have parameter RESET_PC, default 0: PC value loaded at reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be asynchronous and active-low.
REQ-005 mem_req  output  1  memory access request.
REQ-006 mem_we  output  1  write when 1, read when 0; valid only while mem_req=1.
REQ-007 mem_addr  output  DW  byte address.
REQ-008 mem_wdata  output  DW  store data.
REQ-009 mem_rdata  input  DW  read data; sampled only on the edge that completes a read.
REQ-010 mem_ready  input  1  completes the current request when sampled high with mem_req=1.
REQ-011 halted  output  1  core has stopped on an illegal instruction.
REQ-012 retired  output  32  count of completed instructions.

Function
REQ-013 The block SHALL combine a multicycle MIPS datapath with its controller FSM, with states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-014 The supported instructions SHALL be: R-type add/sub/and/or/slt/jr (funct 20/22/24/25/2A/08 hex); addi 08; lw 23; sw 2B; beq 04; j 02; jal 03.
REQ-015 Instruction word SHALL be mem_rdata[31:0]; immediates sign-extend to DW.
REQ-016 Jump target SHALL be {pc[DW-1:28], imm26, 2'b00}.
REQ-017 Branch target SHALL be pc+4+(sext(imm16)<<2).
REQ-018 All arithmetic SHALL be DW-bit modulo 2^DW; slt SHALL be a signed compare; no overflow traps.
REQ-019 Register file SHALL hold 32 x DW bits; register 0 SHALL read 0 and ignore writes; jal SHALL write pc+4 to register 31.
REQ-020 mem_req SHALL be 1 exactly in FETCH and MEM.
REQ-021 mem_addr, mem_we and mem_wdata SHALL stay stable until the completing edge.
REQ-022 A request SHALL complete on the first rising edge with mem_ready=1; mem_ready while mem_req=0 SHALL be ignored.
REQ-023 The FSM SHALL wait in FETCH/MEM indefinitely while mem_ready=0.
REQ-024 FETCH SHALL proceed to DECODE on completion, latching IR and setting pc=pc+4.
REQ-025 DECODE SHALL proceed to EXEC for legal opcodes and to HALT for any illegal opcode or funct.
REQ-026 EXEC SHALL proceed as follows: lw/sw to MEM; R-type (except jr), addi and jal to WB; beq, j and jr update pc and go to FETCH.
REQ-027 MEM SHALL proceed to WB for lw and to FETCH for sw.
REQ-028 WB SHALL proceed to FETCH.
REQ-029 With zero-wait memory, latency SHALL be: beq/j/jr 3 cycles; sw 4; R-type/addi/jal 4; lw 5.
REQ-030 retired SHALL increment by 1 on the edge leaving the instruction's last state to FETCH, and SHALL wrap from 2^32-1 to 0.
REQ-031 HALT SHALL be absorbing: halted=1, mem_req=0, no register or pc changes until reset.
REQ-032 When a store's address equals the following fetch address, the fetch SHALL return the stored data; no internal ordering beyond request order exists.
REQ-033 beq comparing a register with itself SHALL always be taken; target wrap-around SHALL be modulo 2^DW.

Reset
REQ-034 While rst=0: state=FETCH, pc=RESET_PC, IR=0, all registers 0, retired=0, halted=0, and mem_req SHALL be forced 0.
REQ-035 Reset asserted mid-request SHALL abandon the request with no register or memory-side state retained; the first request after release SHALL be a fetch at RESET_PC.

Structure
REQ-036 Package mc_core_pkg SHALL hold the opcode and funct constants, the state enumeration and the ALU operation encoding.
REQ-037 The register file SHALL be sub-module mc_regfile, parametrised by DW, with 2 read ports and 1 write port.
REQ-038 The ALU and FSM SHALL remain inside mc_core_hs.

Verification
REQ-039 Zero-wait memory, program {addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; sw r3,64(r0)} -> mem[64]=2, retired=4 after 16 cycles.
REQ-040 lw with mem_ready low for 3 cycles in MEM -> address and control held constant, lw completes in 8 cycles, register = loaded value.
REQ-041 beq r0,r0,-1 -> pc loops to the same address, retired increments every 3 cycles.
REQ-042 Opcode 3F -> halted=1 after DECODE, mem_req stays 0 for 100 cycles; rst pulse -> fetch at RESET_PC.
REQ-043 DW=64: addi r1,r0,-1; slt r2,r1,r0 -> r1=FFFF_FFFF_FFFF_FFFF, r2=1; jal at 0x100 -> r31=0x104.
REQ-044 rst asserted during a FETCH wait -> mem_req drops asynchronously; after release retired=0 and the first mem_addr=RESET_PC.
